// File: rtl/seg7_pkg.sv
// Shared types and constants for the seven-segment display digit.
// Every encoding here is active-low {g,f,e,d,c,b,a}; 0 means the segment is lit.
package seg7_pkg;

    typedef logic [6:0] seg_t;
    typedef logic [3:0] nibble_t;

    localparam seg_t SEG_OFF = 7'h7F;
    localparam seg_t SEG_ALL = 7'h00;

    localparam seg_t SEG_GLYPH [16] = '{
        7'b1000000,  // 0
        7'b1111001,  // 1
        7'b0100100,  // 2
        7'b0110000,  // 3
        7'b0011001,  // 4
        7'b0010010,  // 5
        7'b0000010,  // 6
        7'b1111000,  // 7
        7'b0000000,  // 8
        7'b0010000,  // 9
        7'b0001000,  // A
        7'b0000011,  // b
        7'b1000110,  // C
        7'b0100001,  // d
        7'b0000110,  // E
        7'b0001110   // F
    };

endpackage

// File: rtl/seg7_lut.sv
// Combinational lookup from a hex nibble to its active-low glyph.
import seg7_pkg::*;

module seg7_lut (
    input  nibble_t i_nibble,
    output seg_t    o_glyph
);

    assign o_glyph = SEG_GLYPH[i_nibble];

endmodule

// File: rtl/seven_seg_decoder.sv
// Registered hex-to-seven-segment digit with blank and lamp-test overrides.
// Define SEG7_ACTIVE_HIGH_EN for common-cathode boards (1 = lit on segment).
import seg7_pkg::*;

module seven_seg_decoder (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] hex_num,
    input  logic       blank,
    input  logic       lamp_test,
    output logic [6:0] segment
);

`ifdef SEG7_ACTIVE_HIGH_EN
    localparam seg_t SEG_RESET = ~SEG_OFF;
`else
    localparam seg_t SEG_RESET = SEG_OFF;
`endif

    nibble_t r_digit;
    logic    r_valid;
    seg_t    r_segment;

    nibble_t w_effDigit;
    seg_t    w_glyph;
    seg_t    w_nextLow;
    seg_t    w_nextSeg;

    // A load bypasses the digit register so its glyph appears on the same edge.
    assign w_effDigit = load ? hex_num : r_digit;

    seg7_lut u_lut (
        .i_nibble (w_effDigit),
        .o_glyph  (w_glyph)
    );

    always_comb begin
        w_nextLow = w_glyph;
        if (lamp_test) begin
            w_nextLow = SEG_ALL;
        end else if (blank || (!r_valid && !load)) begin
            w_nextLow = SEG_OFF;
        end
    end

`ifdef SEG7_ACTIVE_HIGH_EN
    assign w_nextSeg = ~w_nextLow;
`else
    assign w_nextSeg = w_nextLow;
`endif

    // Overrides only steer the output; the digit is captured regardless.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_digit   <= '0;
            r_valid   <= 1'b0;
            r_segment <= SEG_RESET;
        end else begin
            if (load) begin
                r_digit <= hex_num;
                r_valid <= 1'b1;
            end
            r_segment <= w_nextSeg;
        end
    end

    assign segment = r_segment;

endmodule

// File: tb/tb_seven_seg_decoder.sv
// Directed self-checking bench for seven_seg_decoder (either polarity build).
module tb_seven_seg_decoder;

    logic       clk;
    logic       rst_n;
    logic       load;
    logic [3:0] hex_num;
    logic       blank;
    logic       lamp_test;
    logic [6:0] segment;

    int checkCount;
    int failCount;

    logic [6:0] glyphLow [16];

    seven_seg_decoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .hex_num   (hex_num),
        .blank     (blank),
        .lamp_test (lamp_test),
        .segment   (segment)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Convert an active-low expectation into the polarity of this build.
    function automatic logic [6:0] pol(input logic [6:0] lowVal);
`ifdef SEG7_ACTIVE_HIGH_EN
        return ~lowVal;
`else
        return lowVal;
`endif
    endfunction

    task automatic checkOutput(input string tag, input logic [6:0] observed, input logic [6:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %b expected %b", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs, then sample 1 ns after the rising edge.
    task automatic applyStimulus(input logic ld, input logic [3:0] hx, input logic bl, input logic lt);
        load      = ld;
        hex_num   = hx;
        blank     = bl;
        lamp_test = lt;
        @(posedge clk);
        #1;
    endtask

    initial begin
        glyphLow = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                     7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                     7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                     7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        checkCount = 0;
        failCount  = 0;
        rst_n      = 1'b1;
        load       = 1'b0;
        hex_num    = 4'h0;
        blank      = 1'b0;
        lamp_test  = 1'b0;

        #2 rst_n = 1'b0;
        #1 checkOutput("reset_initial", segment, pol(7'h7F));
        @(posedge clk);
        #1 rst_n = 1'b1;

        // No load yet: the digit stays dark.
        applyStimulus(1'b0, 4'h3, 1'b0, 1'b0);
        checkOutput("no_load_dark0", segment, pol(7'h7F));
        applyStimulus(1'b0, 4'h6, 1'b0, 1'b0);
        checkOutput("no_load_dark1", segment, pol(7'h7F));

        // Back-to-back sweep of every code.
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 4'(i), 1'b0, 1'b0);
            checkOutput($sformatf("sweep_%0h", i), segment, pol(glyphLow[i]));
        end

        // Asynchronous reset while showing 8.
        applyStimulus(1'b1, 4'h8, 1'b0, 1'b0);
        checkOutput("show_8", segment, pol(7'b0000000));
        #2 rst_n = 1'b0;
        #1 checkOutput("reset_async", segment, pol(7'h7F));
        #3 rst_n = 1'b1;
        applyStimulus(1'b0, 4'h8, 1'b0, 1'b0);
        checkOutput("after_reset_dark0", segment, pol(7'h7F));
        applyStimulus(1'b0, 4'h1, 1'b0, 1'b0);
        checkOutput("after_reset_dark1", segment, pol(7'h7F));

        // Hold with hex_num wandering.
        applyStimulus(1'b1, 4'h5, 1'b0, 1'b0);
        checkOutput("load_5", segment, pol(7'b0010010));
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 4'($urandom_range(15)), 1'b0, 1'b0);
            checkOutput($sformatf("hold_5_%0d", i), segment, pol(7'b0010010));
        end

        // Blank and release.
        applyStimulus(1'b1, 4'h9, 1'b0, 1'b0);
        checkOutput("load_9", segment, pol(7'b0010000));
        applyStimulus(1'b0, 4'h2, 1'b1, 1'b0);
        checkOutput("blank_on", segment, pol(7'h7F));
        applyStimulus(1'b0, 4'h2, 1'b0, 1'b0);
        checkOutput("blank_off", segment, pol(7'b0010000));

        // Lamp test beats blank; load underneath is still captured.
        applyStimulus(1'b1, 4'hC, 1'b1, 1'b1);
        checkOutput("lamp_over_blank", segment, pol(7'h00));
        applyStimulus(1'b0, 4'h0, 1'b0, 1'b0);
        checkOutput("captured_C", segment, pol(7'b1000110));

        // Lamp test alone, then the held digit returns.
        applyStimulus(1'b0, 4'h7, 1'b0, 1'b1);
        checkOutput("lamp_on", segment, pol(7'h00));
        applyStimulus(1'b0, 4'h7, 1'b0, 1'b0);
        checkOutput("lamp_off", segment, pol(7'b1000110));

        // Load under blank is captured too.
        applyStimulus(1'b1, 4'hE, 1'b1, 1'b0);
        checkOutput("blank_load_E", segment, pol(7'h7F));
        applyStimulus(1'b0, 4'h0, 1'b0, 1'b0);
        checkOutput("captured_E", segment, pol(7'b0000110));

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
